// File: rtl/cache_types.sv
// Shared types and widths for the data cache and its memory-side adapter.
package cache_types;

   localparam int LINE_BITS_C = 256;
   localparam int BEAT_BITS_C = 64;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_DATA,
      WR,
      DONE
   } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Cacheline adapter: turns one dfp line read/write into a BEATS-long burst
// on bmem, and returns an assembled read line with a single-cycle resp.
module cacheline_adapter
   import cache_types::*;
#(
   parameter int LINE_BITS = LINE_BITS_C,
   parameter int BEAT_BITS = BEAT_BITS_C
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          dfp_addr,
   input  logic                 dfp_read,
   input  logic                 dfp_write,
   input  logic [LINE_BITS-1:0] dfp_wdata,
   output logic [LINE_BITS-1:0] dfp_rdata,
   output logic                 dfp_resp,
   output logic [31:0]          bmem_addr,
   output logic                 bmem_read,
   output logic                 bmem_write,
   output logic [BEAT_BITS-1:0] bmem_wdata,
   input  logic                 bmem_ready,
   input  logic [31:0]          bmem_raddr,
   input  logic [BEAT_BITS-1:0] bmem_rdata,
   input  logic                 bmem_rvalid
);

   localparam int             BEATS     = LINE_BITS / BEAT_BITS;
   localparam int             CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0]  LAST      = CW'(BEATS - 1);
   localparam logic [31:0]    ADDR_MASK = 32'hFFFF_FFE0;

   adapter_state_t        state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [31:0]           addr_q, addr_d;
   logic [LINE_BITS-1:0]  wbuf_q, wbuf_d;
   logic [LINE_BITS-1:0]  rbuf_q, rbuf_d;
   // rdata_q is the line the cache sees; it only moves when a read completes
   logic [LINE_BITS-1:0]  rdata_q, rdata_d;

   // State and buffer registers; reset abandons any burst in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wbuf_q  <= '0;
         rbuf_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wbuf_q  <= wbuf_d;
         rbuf_q  <= rbuf_d;
         rdata_q <= rdata_d;
      end
   end

   // Next-state and output decode; outputs depend on registers and bmem only
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wbuf_d     = wbuf_q;
      rbuf_d     = rbuf_q;
      rdata_d    = rdata_q;
      dfp_resp   = 1'b0;
      bmem_read  = 1'b0;
      bmem_write = 1'b0;
      bmem_addr  = '0;
      bmem_wdata = '0;
      unique case (state_q)
         IDLE: begin
            // write wins if the cache illegally raises both
            if (dfp_write) begin
               addr_d  = dfp_addr & ADDR_MASK;
               wbuf_d  = dfp_wdata;
               cnt_d   = '0;
               state_d = WR;
            end else if (dfp_read) begin
               addr_d  = dfp_addr & ADDR_MASK;
               cnt_d   = '0;
               state_d = RD_REQ;
            end
         end
         RD_REQ: begin
            bmem_read = 1'b1;
            bmem_addr = addr_q;
            if (bmem_ready) state_d = RD_DATA;
         end
         RD_DATA: begin
            // beats tagged with another line's address are not ours
            if (bmem_rvalid && (bmem_raddr == addr_q)) begin
               rbuf_d[int'(cnt_q)*BEAT_BITS +: BEAT_BITS] = bmem_rdata;
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  rdata_d = rbuf_d;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         WR: begin
            bmem_write = 1'b1;
            bmem_addr  = addr_q;
            bmem_wdata = wbuf_q[int'(cnt_q)*BEAT_BITS +: BEAT_BITS];
            if (bmem_ready) begin
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         DONE: begin
            dfp_resp = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign dfp_rdata = rdata_q;

endmodule
